// File: rtl/submdl_cmd_sequencer.sv
// Bubble page command sequencer: accepts host RD/WR requests, seeks, streams one page, checks and reports.
// Optional SEEK watchdog enabled by defining SEQ_TIMEOUT_EN (default build waits for i_POS_MATCH indefinitely).
module submdl_cmd_sequencer #(
`ifdef SEQ_TIMEOUT_EN
    parameter int unsigned SEEK_TMO = 1023,
`endif
    parameter int unsigned PAGE_LEN = 576
) (
    input  logic       i_EMUCLK,
    input  logic       i_RST,
    input  logic       i_CEN,
    input  logic       i_RDREQ,
    input  logic       i_WRREQ,
    input  logic       i_POS_MATCH,
    input  logic       i_BIT_STB,
    input  logic       i_CRC_OK,
    input  logic       i_ERR,
    input  logic       i_ERR_CLR,
    output logic [2:0] o_FSMSTAT,
    output logic       o_RDEN,
    output logic       o_WREN,
    output logic       o_BUSY,
    output logic       o_DONE,
    output logic       o_ERR_FLAG
);

    localparam int unsigned CNT_W = $clog2(PAGE_LEN + 1);
`ifdef SEQ_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(SEEK_TMO + 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE    = 3'b000,
        S_SEEK    = 3'b001,
        S_RD_XFER = 3'b010,
        S_WR_XFER = 3'b011,
        S_CHECK   = 3'b100,
        S_DONE    = 3'b101,
        S_ERROR   = 3'b111
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_bit_cnt, w_bit_cnt_nxt;
    logic             r_rd_pend, w_rd_pend_nxt;
    logic             r_wr_pend, w_wr_pend_nxt;
    logic             r_tag_wr, w_tag_wr_nxt;
    logic             r_err_flag, w_err_flag_nxt;
    logic             r_rden, r_wren, r_busy, r_done;
`ifdef SEQ_TIMEOUT_EN
    logic [TMO_W-1:0] r_seek_cnt, w_seek_cnt_nxt;
`endif

    // Next-state, counters, request latches and sticky error flag
    always_comb begin
        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_tag_wr_nxt   = r_tag_wr;
        w_rd_pend_nxt  = r_rd_pend | i_RDREQ;
        w_wr_pend_nxt  = r_wr_pend | i_WRREQ;
        w_err_flag_nxt = i_ERR_CLR ? 1'b0 : r_err_flag;
`ifdef SEQ_TIMEOUT_EN
        w_seek_cnt_nxt = r_seek_cnt;
`endif

        case (r_state)
            S_IDLE: begin
                w_bit_cnt_nxt = '0;
`ifdef SEQ_TIMEOUT_EN
                w_seek_cnt_nxt = '0;
`endif
                if (i_ERR) begin
                    w_err_flag_nxt = 1'b1;
                end else if (!r_err_flag) begin
                    // A pulse arriving on the acceptance edge re-arms the latch
                    if (r_rd_pend) begin
                        w_state_nxt   = S_SEEK;
                        w_tag_wr_nxt  = 1'b0;
                        w_rd_pend_nxt = i_RDREQ;
                    end else if (r_wr_pend) begin
                        w_state_nxt   = S_SEEK;
                        w_tag_wr_nxt  = 1'b1;
                        w_wr_pend_nxt = i_WRREQ;
                    end
                end
            end
            S_SEEK: begin
                w_bit_cnt_nxt = '0;
                if (i_POS_MATCH) begin
                    w_state_nxt = r_tag_wr ? S_WR_XFER : S_RD_XFER;
`ifdef SEQ_TIMEOUT_EN
                end else if (r_seek_cnt == TMO_W'(SEEK_TMO - 1)) begin
                    w_state_nxt    = S_ERROR;
                    w_err_flag_nxt = 1'b1;
                end else begin
                    w_seek_cnt_nxt = r_seek_cnt + TMO_W'(1);
`endif
                end
            end
            S_RD_XFER, S_WR_XFER: begin
                if (i_BIT_STB) begin
                    w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                    if (r_bit_cnt == CNT_W'(PAGE_LEN - 1)) begin
                        w_state_nxt = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (!r_tag_wr && !i_CRC_OK) begin
                    w_state_nxt    = S_ERROR;
                    w_err_flag_nxt = 1'b1;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            S_ERROR: begin
                if (i_ERR_CLR) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Datapath fault overrides every transition; inside ERROR the clear still wins
        if (i_ERR && (r_state != S_IDLE) && (r_state != S_ERROR)) begin
            w_state_nxt    = S_ERROR;
            w_err_flag_nxt = 1'b1;
        end
    end

    // State, counters and registered outputs; frozen while i_CEN=0
    always_ff @(posedge i_EMUCLK or posedge i_RST) begin
        if (i_RST) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= '0;
            r_rd_pend  <= 1'b0;
            r_wr_pend  <= 1'b0;
            r_tag_wr   <= 1'b0;
            r_err_flag <= 1'b0;
            r_rden     <= 1'b0;
            r_wren     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            r_seek_cnt <= '0;
`endif
        end else if (i_CEN) begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_rd_pend  <= w_rd_pend_nxt;
            r_wr_pend  <= w_wr_pend_nxt;
            r_tag_wr   <= w_tag_wr_nxt;
            r_err_flag <= w_err_flag_nxt;
            r_rden     <= (w_state_nxt == S_RD_XFER);
            r_wren     <= (w_state_nxt == S_WR_XFER);
            r_busy     <= (w_state_nxt != S_IDLE);
            r_done     <= (w_state_nxt == S_DONE);
`ifdef SEQ_TIMEOUT_EN
            r_seek_cnt <= w_seek_cnt_nxt;
`endif
        end
    end

    assign o_FSMSTAT  = r_state;
    assign o_RDEN     = r_rden;
    assign o_WREN     = r_wren;
    assign o_BUSY     = r_busy;
    assign o_DONE     = r_done;
    assign o_ERR_FLAG = r_err_flag;

endmodule
